fpu_add_arbiter: RTL and testbench
==================================

# fpu_add_arbiter

Sequencing and sharing controller for the single-precision combinational adder in the tinyriscv FPU. Two requesters, such as the execute stage and a future multi-cycle FMA/convert unit, issue FADD/FSUB operations. The block arbitrates round-robin, registers operands into the shared adder, captures the result with invalid/overflow flags, and returns it over a valid/ready response channel. One operation is in flight at a time.

## Interface
- TAG_W, 5, width of the opaque tag carried from request to response (destination register index)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 accepted this cycle
- req0_op  input  1  0 = add, 1 = subtract (a − b)
- req0_a, req0_b  input  32  IEEE-754 single operands
- req0_tag  input  TAG_W  tag returned with the result
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_tag: same as requester 0, for requester 1
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes the result
- rsp_id  output  1  requester index of the result
- rsp_tag  output  TAG_W  tag of the accepted request
- rsp_result  output  32  sum/difference bits
- rsp_nv  output  1  invalid flag: result is NaN
- rsp_of  output  1  overflow flag: result is ±inf and both operands are finite
- busy  output  1  state ≠ IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- Reset: state = IDLE, rr_last = 1 (requester 0 has priority first). rsp_valid = 0, req0_ready = req1_ready = 0, busy = 0. rsp_id, rsp_tag, rsp_result, rsp_nv and rsp_of are all 0.
- Grant logic, IDLE only, combinational:
  - If only one valid is high, that requester is granted.
  - If both are high, the requester ≠ rr_last is granted.
  - reqN_ready = (state == IDLE) && grantN. At most one ready is high per cycle.
- Acceptance (IDLE, granted valid):
  - Latch op_a = a, op_b = b with bit 31 inverted when op = 1, plus tag and id.
  - rr_last = granted id.
  - Go to EXEC.
- EXEC: the adder is driven from op_a/op_b only. Capture its output into rsp_result.
  - nv = (result[30:23] == 255 && result[22:0] ≠ 0).
  - of = (result[30:23] == 255 && result[22:0] == 0 && op_a[30:23] ≠ 255 && op_b[30:23] ≠ 255).
  - Go to RESP.
- RESP: rsp_valid = 1. Result, id, tag and flags are stable. When rsp_ready = 1, go to IDLE and drop rsp_valid next cycle.
- Data outputs hold their last value outside RESP. Consumers qualify them with rsp_valid only.
- The adder output NaN is canonical 0xFFC00000 or 0x7FC00000 and passes through unchanged. The block does not quieten or re-sign NaNs.
- Requests arriving in EXEC or RESP see ready = 0 and must be held by the requester. Inputs are sampled only at acceptance.
- rst asserted in any state returns to reset values on the next edge. The in-flight operation is discarded with no response.

## Timing
- Accept at edge N (valid && ready), EXEC during cycle N+1, rsp_valid high from cycle N+2.
- With rsp_ready tied high: rsp_valid for one cycle, next accept possible at N+3. Peak throughput is 1 operation per 3 cycles.
- Backpressure: each stall cycle with rsp_ready = 0 adds one cycle. No result is ever dropped or duplicated.
- rsp_ready is ignored when rsp_valid = 0.
- No combinational path from rsp_ready to reqN_ready. Ready depends on state and the valids only.
- Adder critical path: op registers → adder → rsp_result register, a full cycle.

## Test plan
- Single add, req0: a = 0x3F800000, b = 0x40000000, op = 0, tag = 7. Required: ready pulse at N, rsp_valid at N+2, result 0x40400000, id 0, tag 7, nv = 0, of = 0.
- Subtract, req1: a = 0x40400000, b = 0x3F800000, op = 1. Required: result 0x40000000, id 1. Then inf − inf, a = b = 0x7F800000, op = 1. Required: result 0xFFC00000, nv = 1, of = 0.
- Overflow: a = b = 0x7F7FFFFF, op = 0. Required: result 0x7F800000, of = 1, nv = 0. Then a = 0x7F800000, b = 0x3F800000. Required: 0x7F800000, of = 0.
- Arbitration after reset, both valids held continuously with distinct tags. Required: grant order 0, 1, 0, 1; each request served exactly once; rsp_id/rsp_tag match.
- Backpressure: rsp_ready low for 5 cycles in RESP. Required: rsp_valid and data stable for 5 cycles, both readies 0, accept resumes the cycle after handshake.
- Reset mid-operation: assert rst during EXEC. Required: next cycle rsp_valid = 0, busy = 0, no response for that request, and next simultaneous requests grant req0 first.

Source files
------------

// File: rtl/fpu_add_arbiter.sv
// fpu_add_arbiter: round-robin front end for a shared single-precision adder.
// Two requesters issue FADD/FSUB. One operation is in flight at a time:
// IDLE (grant/accept) -> EXEC (adder evaluates registered operands) -> RESP
// (result is held until the consumer takes it).
module fpu_add_arbiter #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_op,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_op,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_result,
    output logic             rsp_nv,
    output logic             rsp_of,
    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // IEEE-754 binary32 addition, round-to-nearest-even, subnormals kept.
    // NaN operands give 0x7FC00000; inf - inf gives 0xFFC00000.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x;
        logic [31:0] y;
        logic [7:0]  ex;
        logic [7:0]  ey;
        logic [7:0]  d;
        logic [26:0] mx;
        logic [26:0] my;
        logic [26:0] my_sh;
        logic [26:0] nrm;
        logic        sticky;
        logic        eff_sub;
        logic        rnd;
        logic        found;
        logic [27:0] sum;
        logic [9:0]  exp_r;
        logic [4:0]  lz;
        logic [4:0]  sh;
        logic [24:0] man_r;
        logic [23:0] man;
        logic [31:0] res;

        // Order operands so x has the larger magnitude; result sign is x's.
        if (a[30:0] < b[30:0]) begin
            x = b;
            y = a;
        end else begin
            x = a;
            y = b;
        end

        // Subnormals use exponent 1 with no hidden bit.
        ex      = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey      = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        mx      = {(x[30:23] != 8'd0), x[22:0], 3'b000};
        my      = {(y[30:23] != 8'd0), y[22:0], 3'b000};
        d       = ex - ey;
        eff_sub = x[31] ^ y[31];

        // Align the smaller operand, folding shifted-out bits into sticky.
        if (d > 8'd26) begin
            my_sh  = 27'd0;
            sticky = |my;
        end else begin
            my_sh  = my >> d;
            sticky = |(my & ~(27'h7FFFFFF << d));
        end
        my_sh[0] = my_sh[0] | sticky;

        if (eff_sub) begin
            sum = {1'b0, mx} - {1'b0, my_sh};
        end else begin
            sum = {1'b0, mx} + {1'b0, my_sh};
        end

        exp_r = {2'b00, ex};
        lz    = 5'd0;
        sh    = 5'd0;
        found = 1'b0;
        if (sum[27]) begin
            // Carry out: shift right one, keep sticky.
            nrm   = {sum[27:2], sum[1] | sum[0]};
            exp_r = exp_r + 10'd1;
        end else begin
            // Normalise left, but never below the subnormal exponent.
            nrm = sum[26:0];
            for (int i = 26; i >= 0; i--) begin
                if (!found && nrm[i]) begin
                    found = 1'b1;
                    lz    = 5'(26 - i);
                end
            end
            if ({5'd0, lz} < (exp_r - 10'd1)) begin
                sh = lz;
            end else begin
                sh = 5'(exp_r - 10'd1);
            end
            nrm   = nrm << sh;
            exp_r = exp_r - {5'd0, sh};
        end

        // Round to nearest, ties to even.
        man   = nrm[26:3];
        rnd   = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
        man_r = {1'b0, man} + {24'd0, rnd};
        if (man_r[24]) begin
            man   = man_r[24:1];
            exp_r = exp_r + 10'd1;
        end else begin
            man = man_r[23:0];
        end

        if ((x[30:23] == 8'hFF) && (x[22:0] != 23'd0)) begin
            res = 32'h7FC00000;
        end else if ((x[30:23] == 8'hFF) && (y[30:23] == 8'hFF) && eff_sub) begin
            res = 32'hFFC00000;
        end else if (x[30:23] == 8'hFF) begin
            res = x;
        end else if (sum == 28'd0) begin
            res = {x[31] & y[31], 31'd0};
        end else if (exp_r >= 10'd255) begin
            res = {x[31], 8'hFF, 23'd0};
        end else begin
            res = {x[31], (man[23] ? exp_r[7:0] : 8'd0), man[22:0]};
        end
        return res;
    endfunction

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             rr_last_q;
    logic [31:0]      op_a_q;
    logic [31:0]      op_b_q;
    logic [TAG_W-1:0] tag_q;
    logic             id_q;
    logic [31:0]      rsp_result_q;
    logic             rsp_nv_q;
    logic             rsp_of_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic             rsp_id_q;
    logic             grant0_s;
    logic             grant1_s;
    logic             accept_s;
    logic [31:0]      add_res_s;
    logic             nv_s;
    logic             of_s;

    // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0_s = rr_last_q;
            grant1_s = !rr_last_q;
        end else begin
            grant0_s = req0_valid;
            grant1_s = req1_valid;
        end
    end

    assign accept_s = (state_q == S_IDLE) && (grant0_s || grant1_s);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs: readies depend only on state and valids, never on rsp_ready.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b0;
        case (state_q)
            S_IDLE: begin
                req0_ready = grant0_s;
                req1_ready = grant1_s;
            end
            S_EXEC: begin
                busy = 1'b1;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Shared adder fed only from the operand registers, plus result flags.
    assign add_res_s = fp_add(op_a_q, op_b_q);
    assign nv_s = (add_res_s[30:23] == 8'hFF) && (add_res_s[22:0] != 23'd0);
    assign of_s = (add_res_s[30:23] == 8'hFF) && (add_res_s[22:0] == 23'd0) &&
                  (op_a_q[30:23] != 8'hFF) && (op_b_q[30:23] != 8'hFF);

    // Operand capture at acceptance; subtraction flips the sign of b.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_q    <= 32'd0;
            op_b_q    <= 32'd0;
            tag_q     <= '0;
            id_q      <= 1'b0;
            rr_last_q <= 1'b1;
        end else if (accept_s) begin
            op_a_q    <= grant1_s ? req1_a : req0_a;
            op_b_q    <= grant1_s ? {req1_b[31] ^ req1_op, req1_b[30:0]}
                                  : {req0_b[31] ^ req0_op, req0_b[30:0]};
            tag_q     <= grant1_s ? req1_tag : req0_tag;
            id_q      <= grant1_s;
            rr_last_q <= grant1_s;
        end
    end

    // Response capture at the end of EXEC; held unchanged until the next EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_result_q <= 32'd0;
            rsp_nv_q     <= 1'b0;
            rsp_of_q     <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_id_q     <= 1'b0;
        end else if (state_q == S_EXEC) begin
            rsp_result_q <= add_res_s;
            rsp_nv_q     <= nv_s;
            rsp_of_q     <= of_s;
            rsp_tag_q    <= tag_q;
            rsp_id_q     <= id_q;
        end
    end

    assign rsp_result = rsp_result_q;
    assign rsp_nv     = rsp_nv_q;
    assign rsp_of     = rsp_of_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Directed bench for fpu_add_arbiter: inputs driven and outputs sampled on the
// falling clock edge, expected values computed by hand.
module tb_fpu_add_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_op;
    logic [31:0] req0_a, req0_b;
    logic [4:0]  req0_tag;
    logic        req1_valid, req1_ready, req1_op;
    logic [31:0] req1_a, req1_b;
    logic [4:0]  req1_tag;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_nv, rsp_of, busy;
    logic [4:0]  rsp_tag;
    logic [31:0] rsp_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fpu_add_arbiter #(.TAG_W(5)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_tag(rsp_tag), .rsp_result(rsp_result), .rsp_nv(rsp_nv),
        .rsp_of(rsp_of), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic set_req(input logic port, input logic op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] tag);
        if (port) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_tag = tag;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_tag = tag;
        end
    endtask

    // Starts and ends at a falling edge with the DUT idle and no request pending.
    task automatic run_op(input string name, input logic port, input logic op,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                          input logic [31:0] exp_res, input logic exp_nv, input logic exp_of);
        set_req(port, op, a, b, tag);
        #1;
        chk({name, "_ready"}, {31'd0, port ? req1_ready : req0_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({name, "_exec_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({name, "_exec_busy"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk({name, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({name, "_result"}, rsp_result, exp_res);
        chk({name, "_id"}, {31'd0, rsp_id}, {31'd0, port});
        chk({name, "_tag"}, {27'd0, rsp_tag}, {27'd0, tag});
        chk({name, "_nv"}, {31'd0, rsp_nv}, {31'd0, exp_nv});
        chk({name, "_of"}, {31'd0, rsp_of}, {31'd0, exp_of});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({name, "_done_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({name, "_done_busy"}, {31'd0, busy}, 32'd0);
    endtask

    logic        arb_id  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [4:0]  arb_tag [4] = '{5'd16, 5'd17, 5'd18, 5'd19};
    logic [31:0] arb_res [4] = '{32'h40400000, 32'h40000000, 32'h40800000, 32'h00000000};

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_op = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_tag = 5'd0;
        req1_valid = 1'b0; req1_op = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_tag = 5'd0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_tag", {27'd0, rsp_tag}, 32'd0);
        chk("rst_id", {31'd0, rsp_id}, 32'd0);
        chk("rst_flags", {30'd0, rsp_nv, rsp_of}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Arbitration right after reset: both requesters held valid.
        set_req(1'b0, 1'b0, 32'h3F800000, 32'h40000000, 5'd16);
        set_req(1'b1, 1'b1, 32'h40400000, 32'h3F800000, 5'd17);
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("arb_ready0", {31'd0, req0_ready}, {31'd0, !arb_id[k]});
            chk("arb_ready1", {31'd0, req1_ready}, {31'd0, arb_id[k]});
            @(negedge clk);
            if (k == 0) set_req(1'b0, 1'b0, 32'h40000000, 32'h40000000, 5'd18);
            if (k == 1) set_req(1'b1, 1'b1, 32'h3F800000, 32'h3F800000, 5'd19);
            if (k == 2) req0_valid = 1'b0;
            if (k == 3) req1_valid = 1'b0;
            chk("arb_exec_readies", {30'd0, req0_ready, req1_ready}, 32'd0);
            @(negedge clk);
            chk("arb_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("arb_rsp_id", {31'd0, rsp_id}, {31'd0, arb_id[k]});
            chk("arb_rsp_tag", {27'd0, rsp_tag}, {27'd0, arb_tag[k]});
            chk("arb_rsp_result", rsp_result, arb_res[k]);
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        chk("arb_no_extra", {31'd0, rsp_valid}, 32'd0);
        chk("arb_idle", {31'd0, busy}, 32'd0);

        // Single operations, including special values and rounding ties.
        run_op("add0", 1'b0, 1'b0, 32'h3F800000, 32'h40000000, 5'd7, 32'h40400000, 1'b0, 1'b0);
        run_op("sub1", 1'b1, 1'b1, 32'h40400000, 32'h3F800000, 5'd1, 32'h40000000, 1'b0, 1'b0);
        run_op("infinf", 1'b1, 1'b1, 32'h7F800000, 32'h7F800000, 5'd2, 32'hFFC00000, 1'b1, 1'b0);
        run_op("ovf", 1'b0, 1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 5'd5, 32'h7F800000, 1'b0, 1'b1);
        run_op("infpl", 1'b0, 1'b0, 32'h7F800000, 32'h3F800000, 5'd6, 32'h7F800000, 1'b0, 1'b0);
        run_op("tie_even", 1'b1, 1'b0, 32'h3F800000, 32'h33800000, 5'd8, 32'h3F800000, 1'b0, 1'b0);
        run_op("tie_odd", 1'b0, 1'b0, 32'h3F800001, 32'h33800000, 5'd9, 32'h3F800002, 1'b0, 1'b0);

        // Backpressure: five cycles of rsp_ready low, a new request waiting.
        set_req(1'b0, 1'b0, 32'h3F800000, 32'h3F800000, 5'd3);
        #1;
        chk("bp_ready", {31'd0, req0_ready}, 32'd1);
        @(negedge clk);
        set_req(1'b0, 1'b0, 32'h40000000, 32'h3F800000, 5'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_result", rsp_result, 32'h40000000);
            chk("bp_tag", {27'd0, rsp_tag}, 32'd3);
            chk("bp_readies", {30'd0, req0_ready, req1_ready}, 32'd0);
        end
        @(negedge clk);
        chk("bp_still_valid", {31'd0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_drop_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp_resume_ready", {31'd0, req0_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("bp2_valid", {31'd0, rsp_valid}, 32'd1);
        chk("bp2_result", rsp_result, 32'h40400000);
        chk("bp2_tag", {27'd0, rsp_tag}, 32'd4);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp2_done", {31'd0, rsp_valid}, 32'd0);

        // Reset during EXEC after a req0 grant; req0 must still win afterwards.
        set_req(1'b0, 1'b0, 32'h3F800000, 32'h3F800000, 5'd10);
        #1;
        chk("rm_ready", {31'd0, req0_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("rm_in_exec", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rm_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rm_busy", {31'd0, busy}, 32'd0);
        chk("rm_result", rsp_result, 32'd0);
        chk("rm_tag", {27'd0, rsp_tag}, 32'd0);
        set_req(1'b0, 1'b0, 32'h40000000, 32'h40000000, 5'd12);
        set_req(1'b1, 1'b0, 32'h3F800000, 32'h40000000, 5'd13);
        #1;
        chk("rm_grant0", {30'd0, req0_ready, req1_ready}, 32'd2);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("rm_no_rsp", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("rm_rsp0_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rm_rsp0_id", {31'd0, rsp_id}, 32'd0);
        chk("rm_rsp0_tag", {27'd0, rsp_tag}, 32'd12);
        chk("rm_rsp0_result", rsp_result, 32'h40800000);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rm_grant1", {30'd0, req0_ready, req1_ready}, 32'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        chk("rm_rsp1_id", {31'd0, rsp_id}, 32'd1);
        chk("rm_rsp1_tag", {27'd0, rsp_tag}, 32'd13);
        chk("rm_rsp1_result", rsp_result, 32'h40400000);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rm_final_idle", {30'd0, rsp_valid, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
